// File: rtl/npu_pkg.sv
// npu_pkg: shared types and sizing helpers for the NPU input-load path.
package npu_pkg;
    localparam int AXI_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        FLUSH,
        WAIT_READY,
        DONE
    } load_state_t;

    function automatic int num_words(input int w, input int h);
        return w * h;
    endfunction

    function automatic int count_w(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction
endpackage

// File: rtl/load_word_counter.sv
// load_word_counter: clearable up-counter with a terminal-count flag.
module load_word_counter #(
    parameter int W    = 8,
    parameter int TERM = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_term
);
    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_inc)
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;
    assign o_term  = r_count == W'(TERM);
endmodule

// File: rtl/input_load_controller.sv
// input_load_controller: streams one frame of words into input_buffer, flushes, then waits for ready.
// Optional WAIT_READY timeout with sticky error: define LOAD_TIMEOUT_EN.
module input_load_controller
    import npu_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int INPUT_WIDTH  = 9,
    parameter int INPUT_HEIGHT = 9,
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 256,
    localparam int NUM_WORDS   = num_words(INPUT_WIDTH, INPUT_HEIGHT),
    localparam int COUNT_W     = count_w(INPUT_WIDTH, INPUT_HEIGHT)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [AXI_DATA_W-1:0] i_s_data,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    output logic [AXI_DATA_W-1:0] o_buf_data_in,
    output logic                  o_buf_write_enable,
    output logic                  o_buf_reset,
    input  logic                  i_buf_ready,
    output logic                  o_busy,
    output logic [COUNT_W-1:0]    o_word_count,
    output logic                  o_frame_done,
    output logic                  o_error
);
    if (WIDTH < 1 || FLUSH_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
        $error("input_load_controller: WIDTH, FLUSH_CYCLES and TIMEOUT must be positive");
    end

    load_state_t           r_state;
    logic                  r_s_ready;
    logic [AXI_DATA_W-1:0] r_data;
    logic                  r_we;
    logic                  r_buf_reset;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  w_hs;
    logic                  w_clr;
    logic                  w_word_term;
    logic                  w_flush_term;
    logic [COUNT_W-1:0]    w_word_count;
    logic [$clog2(FLUSH_CYCLES+1)-1:0] w_unused_flush_count;

    // s_ready is high exactly while in LOAD, so the handshake needs no state decode.
    assign w_hs  = i_s_valid & r_s_ready;
    assign w_clr = (r_state == IDLE) & i_start;

    load_word_counter #(.W(COUNT_W), .TERM(NUM_WORDS - 1)) u_word_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_inc   (w_hs),
        .o_count (w_word_count),
        .o_term  (w_word_term)
    );

    load_word_counter #(.W($clog2(FLUSH_CYCLES+1)), .TERM(FLUSH_CYCLES)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_inc   ((r_state == FLUSH) & ~w_flush_term),
        .o_count (w_unused_flush_count),
        .o_term  (w_flush_term)
    );

`ifdef LOAD_TIMEOUT_EN
    logic                           r_error;
    logic                           w_tmo_term;
    logic [$clog2(TIMEOUT+1)-1:0]   w_unused_tmo_count;

    load_word_counter #(.W($clog2(TIMEOUT+1)), .TERM(TIMEOUT - 1)) u_tmo_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_inc   ((r_state == WAIT_READY) & ~i_buf_ready),
        .o_count (w_unused_tmo_count),
        .o_term  (w_tmo_term)
    );
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_s_ready    <= 1'b0;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_buf_reset  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            r_error      <= 1'b0;
`endif
        end else begin
            r_we         <= 1'b0;
            r_buf_reset  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_state     <= CLEAR;
                    r_buf_reset <= 1'b1;
                    r_busy      <= 1'b1;
                end
                CLEAR: begin
                    r_state   <= LOAD;
                    r_s_ready <= 1'b1;
                end
                LOAD: if (w_hs) begin
                    r_we   <= 1'b1;
                    r_data <= i_s_data;
                    if (w_word_term) begin
                        r_state   <= FLUSH;
                        r_s_ready <= 1'b0;
                    end
                end
                // First FLUSH cycle carries the last data write; the zero writes follow.
                FLUSH: if (!w_flush_term) begin
                    r_we   <= 1'b1;
                    r_data <= '0;
                end else begin
                    r_state <= WAIT_READY;
                end
                WAIT_READY: if (i_buf_ready) begin
                    r_state      <= DONE;
                    r_frame_done <= 1'b1;
                end
`ifdef LOAD_TIMEOUT_EN
                else if (w_tmo_term) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_error <= 1'b1;
                end
`endif
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_s_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_s_ready          = r_s_ready;
    assign o_buf_data_in      = r_data;
    assign o_buf_write_enable = r_we;
    assign o_buf_reset        = r_buf_reset;
    assign o_busy             = r_busy;
    assign o_word_count       = w_word_count;
    assign o_frame_done       = r_frame_done;
`ifdef LOAD_TIMEOUT_EN
    assign o_error            = r_error;
`else
    assign o_error            = 1'b0;
`endif
endmodule

// File: tb/tb_input_load_controller.sv
// tb_input_load_controller: randomized scoreboard bench for input_load_controller.
module tb_input_load_controller;
    localparam int NW = 81;
    localparam int FL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic        buf_ready = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, we, brst, busy, fdone, err;
    logic [31:0] bdata;
    logic [6:0]  wc;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          brst_cnt = 0;
    int          exp_done = 0;
    int          exp_brst = 0;
    logic        prev_fdone = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] words[NW+2];

    input_load_controller dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_start            (start),
        .i_s_data           (s_data),
        .i_s_valid          (s_valid),
        .o_s_ready          (s_ready),
        .o_buf_data_in      (bdata),
        .o_buf_write_enable (we),
        .o_buf_reset        (brst),
        .i_buf_ready        (buf_ready),
        .o_busy             (busy),
        .o_word_count       (wc),
        .o_frame_done       (fdone),
        .o_error            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every buffer write must match the next word the frame rules predict.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: data %0h written, no write expected", bdata);
                end else begin
                    check("write_data", bdata, exp_q.pop_front());
                end
            end
            if (brst) begin
                brst_cnt++;
                check("clear_word_count", 32'(wc), 0);
                check("clear_s_ready", 32'(s_ready), 0);
            end
            if (fdone) begin
                done_cnt++;
                check("done_word_count", 32'(wc), NW);
                check("done_pending_writes", exp_q.size(), 0);
                check("done_single_pulse", 32'(prev_fdone), 0);
            end
            prev_fdone = fdone;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 0);
        check({tag, "_data"}, bdata, 0);
        check({tag, "_we"}, 32'(we), 0);
        check({tag, "_buf_reset"}, 32'(brst), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_word_count"}, 32'(wc), 0);
        check({tag, "_frame_done"}, 32'(fdone), 0);
        check({tag, "_error"}, 32'(err), 0);
    endtask

    // vmode: 0 valid held, 1 toggling, 2 random. start_at pulses start mid-load.
    task automatic run_frame(input int n_offer, input int vmode, input bit seq,
                             input bit rdy_early, input int start_at, output int accepted);
        int   idx = 0;
        int   cyc = 0;
        logic took;
        for (int i = 0; i < n_offer; i++) words[i] = seq ? 32'(i + 1) : $urandom;
        for (int i = 0; i < n_offer && i < NW; i++) exp_q.push_back(words[i]);
        if (n_offer >= NW) for (int i = 0; i < FL; i++) exp_q.push_back(32'h0);
        buf_ready = rdy_early;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        exp_brst++;
        while (idx < n_offer && cyc < 400) begin
            s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            s_data  = words[idx];
            start   = (cyc == start_at);
            @(negedge clk);
            took = s_valid && s_ready;
            @(posedge clk); #1;
            if (took) idx++;
            cyc++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        accepted = idx;
    endtask

    task automatic finish_frame(input int ready_delay, input bit start_in_done);
        logic got = 1'b0;
        for (int i = 0; i < ready_delay; i++) @(posedge clk);
        #1 buf_ready = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = fdone;
        end
        check("frame_done_seen", 32'(got), 1);
        exp_done++;
        if (start_in_done) start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        buf_ready = 1'b0;
    endtask

    initial begin
        int acc;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;

        // Sequential words, valid held, buf_ready already high.
        run_frame(NW, 0, 1'b1, 1'b1, -1, acc);
        check("t1_accepted", acc, NW);
        finish_frame(0, 1'b0);

        // Toggling valid with random data.
        run_frame(NW, 1, 1'b0, 1'b0, -1, acc);
        check("t2_accepted", acc, NW);
        finish_frame(3, 1'b0);

        // Source offers two extra words; they must never be taken.
        run_frame(NW + 2, 0, 1'b0, 1'b0, -1, acc);
        check("t3_accepted", acc, NW);
        check("t3_s_ready_low", 32'(s_ready), 0);
        finish_frame(5, 1'b0);

        // start during LOAD and coincident with frame_done must be ignored.
        run_frame(NW, 0, 1'b0, 1'b0, 20, acc);
        check("t4_accepted", acc, NW);
        finish_frame(2, 1'b1);
        repeat (10) @(negedge clk);
        check("t4_idle_after_ignored_start", 32'(busy), 0);
        check("t4_done_count", done_cnt, exp_done);

        // Reset mid-frame after 40 words, then a clean frame.
        run_frame(40, 0, 1'b0, 1'b0, -1, acc);
        check("t5_accepted", acc, 40);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        check("t5_pending_writes", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        run_frame(NW, 2, 1'b0, 1'b0, -1, acc);
        check("t5_restart_accepted", acc, NW);
        finish_frame(1, 1'b0);

        for (int f = 0; f < 2; f++) begin
            run_frame(NW, 2, 1'b0, 1'($urandom_range(0, 1)), -1, acc);
            check("rand_accepted", acc, NW);
            finish_frame(int'($urandom_range(0, 6)), 1'b0);
        end

        repeat (5) @(negedge clk);
        check("final_done_count", done_cnt, exp_done);
        check("final_buf_reset_count", brst_cnt, exp_brst);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_error", 32'(err), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_load_controller.md
Name: input_load_controller

Overview:
Sequences one frame of input feature-map words from the AXI-side stream into input_buffer. Owns the buffer's reset, write_enable and data_in, counts words, and issues the trailing flush writes that make the buffer latch its feature maps. Waits for input_buffer_ready, then signals frame completion to the downstream data_preprocessing_unit / compute sequencer.

Parameters:
WIDTH, 4, bits per feature element (passed through for consistency with input_buffer).
INPUT_WIDTH, 9, feature-map width in elements.
INPUT_HEIGHT, 9, feature-map height in elements.
FLUSH_CYCLES, 2, extra write_enable cycles after the last word (pipeline drain plus latch).
TIMEOUT, 256, WAIT_READY cycle limit; used only with the optional feature.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  begin loading one frame; sampled only in IDLE.
s_data  in  32  stream word from the AXI interface.
s_valid  in  1  s_data valid.
s_ready  out  1  controller accepts a word this cycle.
buf_data_in  out  32  to input_buffer data_in.
buf_write_enable  out  1  to input_buffer write_enable.
buf_reset  out  1  to input_buffer reset (active-high).
buf_ready  in  1  from input_buffer input_buffer_ready.
busy  out  1  high in every state except IDLE.
word_count  out  COUNT_W  words accepted in the current frame.
frame_done  out  1  one-cycle pulse when the frame is latched.
error  out  1  sticky timeout flag (optional feature only).

Behaviour:
- NUM_WORDS = INPUT_WIDTH*INPUT_HEIGHT (81 by default). COUNT_W = clog2(NUM_WORDS+1).
- Reset asserted (reset=0), at any time including mid-frame:
  - State goes to IDLE immediately.
  - All outputs 0: s_ready, buf_data_in, buf_write_enable, buf_reset, busy, word_count, frame_done, error.
- State machine: IDLE -> CLEAR -> LOAD -> FLUSH -> WAIT_READY -> DONE -> IDLE.
- IDLE:
  - s_ready=0.
  - start=1 moves to CLEAR next cycle; otherwise the block stays in IDLE.
- CLEAR (exactly 1 cycle):
  - buf_reset=1.
  - word_count cleared to 0.
  - Moves to LOAD.
- LOAD:
  - s_ready=1, decoded from state only; no combinational path from s_valid.
  - A handshake (s_valid&&s_ready) at edge N drives buf_write_enable=1 and buf_data_in=s_data during cycle N+1 (1-cycle registered latency).
  - word_count increments on each handshake.
  - Cycles without a handshake drive buf_write_enable=0 and hold buf_data_in.
  - Handshake with word_count==NUM_WORDS-1 moves to FLUSH; s_ready drops the next cycle.
  - No word beyond NUM_WORDS is ever accepted.
- FLUSH (FLUSH_CYCLES cycles, following the last data write):
  - buf_write_enable=1, buf_data_in=0.
  - Moves to WAIT_READY.
- WAIT_READY:
  - buf_write_enable=0.
  - buf_ready=1 moves to DONE.
  - If buf_ready is already high on entry, moves to DONE after 1 cycle.
- DONE (1 cycle):
  - frame_done=1.
  - Moves to IDLE; word_count holds NUM_WORDS until the next CLEAR.
- busy=1 in every state except IDLE.
- start outside IDLE is ignored; there is no queueing, including start coincident with frame_done.
- s_valid while s_ready=0 is left pending; the source must hold s_data (AXI-stream rule).
- Counter arithmetic is unsigned, COUNT_W wide, and never wraps within a frame.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- When defined:
  - A WAIT_READY cycle counter runs.
  - If buf_ready is not seen within TIMEOUT cycles, error is set (sticky until reset) and the state goes to IDLE without frame_done.
  - start is still honoured afterwards.
- When undefined:
  - WAIT_READY waits indefinitely.
  - error is tied to 0 and no counter is built.

Decomposition:
- Shared package npu_pkg:
  - load_state_t enum (IDLE, CLEAR, LOAD, FLUSH, WAIT_READY, DONE).
  - AXI data width constant (32).
  - A function or constant for NUM_WORDS/COUNT_W from INPUT_WIDTH/INPUT_HEIGHT.
- One natural sub-module, load_word_counter: a parameterised clear/increment counter with a terminal-count flag. It is reused for the word count and the flush/timeout counts.

Test Plan:
1. Reset, then start pulse, then 81 words 0x1..0x51 with s_valid held high -> buf_reset for 1 cycle, 81 buf_write_enable cycles carrying 0x1..0x51 in order, 2 flush writes of 0, frame_done after buf_ready, word_count=81.
2. s_valid toggled 1/0 every cycle during LOAD -> writes only follow handshakes; data order is preserved; no duplicate or lost words; total writes = 81+2.
3. Source offers 83 words -> s_ready stays low after the 81st handshake; words 82 and 83 are never written.
4. start pulsed during LOAD and during DONE -> no effect; exactly one frame_done per accepted start.
5. reset asserted after 40 words -> all outputs 0 in the same cycle; a following start gives a clean frame with buf_reset and word_count restarting from 0.
6. With LOAD_TIMEOUT_EN and TIMEOUT=16, buf_ready held low -> error=1 after 16 WAIT_READY cycles, state IDLE, no frame_done; error stays 1 until reset.
